fc_layer_sequencer: RTL and testbench

- Time-multiplexed controller for a fully-connected layer, using one signed MAC.
- Walks OUT_SIZE neurons by IN_SIZE inputs.
- Issues read addresses to the external input, weight and bias memories; all three have 1-cycle synchronous read latency.
- Accumulates each neuron's result, adds the bias, applies optional ReLU and saturation, then writes the result to the output memory.
- Replaces the fully-parallel flattened FC layer where area matters; same start/done contract.

---
 rtl/fc_layer_sequencer.sv | 154 +++++++++++++++
 tb/tb_fc_layer_sequencer.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_layer_sequencer.sv
// Time-multiplexed fully-connected layer controller: one signed MAC walks
// OUT_SIZE neurons by IN_SIZE inputs, adds bias, optional ReLU, saturates.
module fc_layer_sequencer #(
    parameter int IN_SIZE   = 16,
    parameter int OUT_SIZE  = 8,
    parameter int W         = 8,
    parameter int ACC_WIDTH = 20,
    parameter int RELU_EN   = 0,
    localparam int IA_W = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1,
    localparam int WA_W = (OUT_SIZE * IN_SIZE > 1) ? $clog2(OUT_SIZE * IN_SIZE) : 1,
    localparam int NA_W = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic [IA_W-1:0]        in_addr,
    input  logic signed [W-1:0]    in_data,
    output logic [WA_W-1:0]        w_addr,
    input  logic signed [W-1:0]    w_data,
    output logic [NA_W-1:0]        b_addr,
    input  logic signed [W-1:0]    b_data,
    output logic                   out_we,
    output logic [NA_W-1:0]        out_addr,
    output logic signed [W-1:0]    out_data,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [IA_W-1:0] K_LAST = IA_W'(IN_SIZE - 1);
    localparam logic [NA_W-1:0] N_LAST = NA_W'(OUT_SIZE - 1);
    localparam logic signed [ACC_WIDTH:0] SAT_MAX = {{(ACC_WIDTH-W+2){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] SAT_MIN = {{(ACC_WIDTH-W+2){1'b1}}, {(W-1){1'b0}}};

    function automatic logic signed [ACC_WIDTH:0] relu(input logic signed [ACC_WIDTH:0] v);
        if (RELU_EN != 0 && v[ACC_WIDTH]) begin
            return '0;
        end
        return v;
    endfunction

    function automatic logic signed [W-1:0] saturate(input logic signed [ACC_WIDTH:0] v);
        if (v > SAT_MAX) begin
            return SAT_MAX[W-1:0];
        end else if (v < SAT_MIN) begin
            return SAT_MIN[W-1:0];
        end
        return v[W-1:0];
    endfunction

    state_t                        state_q, state_d;
    logic [NA_W-1:0]               n_q, n_d;
    logic [IA_W-1:0]               k_q, k_d;
    logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [NA_W-1:0]               out_addr_q, out_addr_d;
    logic signed [W-1:0]           out_data_q, out_data_d;

    logic signed [2*W-1:0]         prod;
    logic signed [ACC_WIDTH-1:0]   prod_ext;
    logic signed [ACC_WIDTH-1:0]   acc_add;
    logic signed [ACC_WIDTH:0]     sum_ext;

    // Memory data arriving this cycle belongs to the address issued last cycle.
    assign prod     = in_data * w_data;
    assign prod_ext = $signed({{(ACC_WIDTH-2*W){prod[2*W-1]}}, prod});
    assign acc_add  = acc_q + prod_ext;
    assign sum_ext  = $signed({acc_add[ACC_WIDTH-1], acc_add})
                    + $signed({{(ACC_WIDTH+1-W){b_data[W-1]}}, b_data});

    assign in_addr  = k_q;
    assign w_addr   = WA_W'(int'(n_q) * IN_SIZE + int'(k_q));
    assign b_addr   = n_q;
    assign out_addr = out_addr_q;
    assign out_data = out_data_q;
    assign out_we   = (state_q == S_WRITE);
    assign busy     = (state_q == S_RUN) || (state_q == S_DRAIN) || (state_q == S_WRITE);
    assign done     = (state_q == S_DONE);

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        k_d        = k_q;
        acc_d      = acc_q;
        out_addr_d = out_addr_q;
        out_data_d = out_data_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    n_d     = '0;
                    k_d     = '0;
                    acc_d   = '0;
                end
            end
            S_RUN: begin
                // No product is in flight yet on the first input of a neuron.
                acc_d = (k_q == '0) ? '0 : acc_add;
                if (k_q == K_LAST) begin
                    k_d     = '0;
                    state_d = S_DRAIN;
                end else begin
                    k_d = k_q + IA_W'(1);
                end
            end
            S_DRAIN: begin
                acc_d      = acc_add;
                out_addr_d = n_q;
                out_data_d = saturate(relu(sum_ext));
                state_d    = S_WRITE;
            end
            S_WRITE: begin
                if (n_q == N_LAST) begin
                    state_d = S_DONE;
                end else begin
                    n_d     = n_q + NA_W'(1);
                    k_d     = '0;
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            n_q        <= '0;
            k_q        <= '0;
            acc_q      <= '0;
            out_addr_q <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            k_q        <= k_d;
            acc_q      <= acc_d;
            out_addr_q <= out_addr_d;
            out_data_q <= out_data_d;
        end
    end

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Bench for fc_layer_sequencer: two instances (ReLU off/on) fed by synchronous
// memory models, checked against a dot-product reference model.
module tb_fc_layer_sequencer;

    localparam int IN_SIZE   = 16;
    localparam int OUT_SIZE  = 8;
    localparam int W         = 8;
    localparam int ACC_WIDTH = 20;
    localparam int NCYC      = IN_SIZE + 2;
    localparam int BUDGET    = 300;

    logic clk = 1'b0;
    logic reset, start;

    logic [3:0] in_addr, in_addr_r;
    logic [6:0] w_addr, w_addr_r;
    logic [2:0] b_addr, b_addr_r, out_addr, out_addr_r;
    logic signed [W-1:0] in_data, w_data, b_data, out_data;
    logic signed [W-1:0] in_data_r, w_data_r, b_data_r, out_data_r;
    logic out_we, out_we_r, busy, busy_r, done, done_r;

    int x_mem[IN_SIZE];
    int w_mem[OUT_SIZE*IN_SIZE];
    int b_mem[OUT_SIZE];

    int tests_run = 0;
    int tests_failed = 0;

    int wr_n, wr_addr[16], wr_data[16], wr_rel[16];
    int wrr_n, wrr_addr[16], wrr_data[16];
    int done_cnt, done_rel, done_r_cnt;
    int ia_log[BUDGET+1], wa_log[BUDGET+1], ba_log[BUDGET+1];
    logic busy_log[BUDGET+1];

    always #5 clk = ~clk;

    fc_layer_sequencer #(.IN_SIZE(IN_SIZE), .OUT_SIZE(OUT_SIZE), .W(W),
                         .ACC_WIDTH(ACC_WIDTH), .RELU_EN(0)) dut (
        .clk(clk), .reset(reset), .start(start),
        .in_addr(in_addr), .in_data(in_data),
        .w_addr(w_addr), .w_data(w_data),
        .b_addr(b_addr), .b_data(b_data),
        .out_we(out_we), .out_addr(out_addr), .out_data(out_data),
        .busy(busy), .done(done)
    );

    fc_layer_sequencer #(.IN_SIZE(IN_SIZE), .OUT_SIZE(OUT_SIZE), .W(W),
                         .ACC_WIDTH(ACC_WIDTH), .RELU_EN(1)) dut_r (
        .clk(clk), .reset(reset), .start(start),
        .in_addr(in_addr_r), .in_data(in_data_r),
        .w_addr(w_addr_r), .w_data(w_data_r),
        .b_addr(b_addr_r), .b_data(b_data_r),
        .out_we(out_we_r), .out_addr(out_addr_r), .out_data(out_data_r),
        .busy(busy_r), .done(done_r)
    );

    // Synchronous-read memories, one read port per instance.
    always @(posedge clk) begin
        in_data   <= 8'(x_mem[in_addr]);
        w_data    <= 8'(w_mem[w_addr]);
        b_data    <= 8'(b_mem[b_addr]);
        in_data_r <= 8'(x_mem[in_addr_r]);
        w_data_r  <= 8'(w_mem[w_addr_r]);
        b_data_r  <= 8'(b_mem[b_addr_r]);
    end

    function automatic int ref_out(input int n, input int relu_on);
        int s;
        s = b_mem[n];
        for (int k = 0; k < IN_SIZE; k++) s += x_mem[k] * w_mem[n*IN_SIZE+k];
        if (relu_on != 0 && s < 0) s = 0;
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        return s;
    endfunction

    task automatic load_nominal();
        int wp[4] = '{1, 1, -1, 0};
        for (int k = 0; k < IN_SIZE; k++) x_mem[k] = k + 1;
        for (int n = 0; n < OUT_SIZE; n++) begin
            b_mem[n] = -36 + 4*n;
            for (int k = 0; k < IN_SIZE; k++) w_mem[n*IN_SIZE+k] = wp[k%4];
        end
    endtask

    task automatic load_random();
        for (int k = 0; k < IN_SIZE; k++) x_mem[k] = int'($urandom_range(255)) - 128;
        for (int i = 0; i < OUT_SIZE*IN_SIZE; i++) w_mem[i] = int'($urandom_range(255)) - 128;
        for (int n = 0; n < OUT_SIZE; n++) b_mem[n] = int'($urandom_range(255)) - 128;
    endtask

    // Starts a layer (start high for start_len cycles, plus an extra pulse in
    // cycle mid_rel) and records everything observed, cycle-numbered so that
    // the accepting edge is edge 0 and cycle 1 follows it.
    task automatic run_layer(input int start_len, input int mid_rel, input int tail);
        int r;
        wr_n = 0; wrr_n = 0; done_cnt = 0; done_rel = -1; done_r_cnt = 0;
        start = 1'b1;
        @(posedge clk); @(negedge clk);
        r = 1;
        forever begin
            ia_log[r] = int'(in_addr); wa_log[r] = int'(w_addr);
            ba_log[r] = int'(b_addr); busy_log[r] = busy;
            if (out_we) begin
                if (wr_n < 16) begin
                    wr_addr[wr_n] = int'(out_addr); wr_data[wr_n] = int'(out_data); wr_rel[wr_n] = r;
                end
                wr_n++;
            end
            if (out_we_r) begin
                if (wrr_n < 16) begin
                    wrr_addr[wrr_n] = int'(out_addr_r); wrr_data[wrr_n] = int'(out_data_r);
                end
                wrr_n++;
            end
            if (done) begin
                done_cnt++;
                if (done_rel < 0) done_rel = r;
            end
            if (done_r) done_r_cnt++;
            if ((done_rel >= 0 && r >= done_rel + tail) || r >= BUDGET) break;
            start = (r < start_len) || (r == mid_rel);
            @(posedge clk); @(negedge clk);
            r++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if ({busy, done, out_we} !== 3'b000) begin
            tests_failed++; $display("FAIL reset_ctrl: got %b expected 000", {busy, done, out_we});
        end
        tests_run++;
        if ({in_addr, w_addr, b_addr, out_addr} !== 17'd0) begin
            tests_failed++; $display("FAIL reset_addr: got %h expected 0", {in_addr, w_addr, b_addr, out_addr});
        end
        tests_run++;
        if (out_data !== 8'sd0) begin
            tests_failed++; $display("FAIL reset_data: got %0d expected 0", out_data);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_nominal();
        int exp_v[8] = '{-12, -8, -4, 0, 4, 8, 12, 16};
        load_nominal();
        run_layer(1, -1, 2);
        tests_run++;
        if (wr_n !== 8) begin tests_failed++; $display("FAIL nominal_we_count: got %0d expected 8", wr_n); end
        tests_run++;
        if (done_rel !== 145) begin tests_failed++; $display("FAIL nominal_done_cycle: got %0d expected 145", done_rel); end
        tests_run++;
        if (done_cnt !== 1) begin tests_failed++; $display("FAIL nominal_done_count: got %0d expected 1", done_cnt); end
        tests_run++;
        if ({busy_log[144], busy_log[145], busy_log[146]} !== 3'b100) begin
            tests_failed++; $display("FAIL nominal_busy_end: got %b expected 100", {busy_log[144], busy_log[145], busy_log[146]});
        end
        for (int n = 0; n < 8 && n < wr_n; n++) begin
            tests_run++;
            if (wr_addr[n] !== n || wr_data[n] !== exp_v[n] || wr_rel[n] !== n*NCYC + NCYC) begin
                tests_failed++;
                $display("FAIL nominal_write[%0d]: got addr %0d data %0d cycle %0d expected addr %0d data %0d cycle %0d",
                         n, wr_addr[n], wr_data[n], wr_rel[n], n, exp_v[n], n*NCYC + NCYC);
            end
        end
    endtask

    task automatic test_relu();
        int exp_v[8] = '{0, 0, 0, 0, 4, 8, 12, 16};
        load_nominal();
        run_layer(1, -1, 2);
        tests_run++;
        if (wrr_n !== 8 || done_r_cnt !== 1) begin
            tests_failed++; $display("FAIL relu_counts: got we %0d done %0d expected 8 1", wrr_n, done_r_cnt);
        end
        for (int n = 0; n < 8 && n < wrr_n; n++) begin
            tests_run++;
            if (wrr_addr[n] !== n || wrr_data[n] !== exp_v[n]) begin
                tests_failed++;
                $display("FAIL relu_write[%0d]: got addr %0d data %0d expected addr %0d data %0d",
                         n, wrr_addr[n], wrr_data[n], n, exp_v[n]);
            end
        end
    endtask

    task automatic test_saturation();
        int wv[2] = '{127, -128};
        int exp_v[2] = '{127, -128};
        int exp_r[2] = '{127, 0};
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < IN_SIZE; k++) x_mem[k] = 127;
            for (int i = 0; i < OUT_SIZE*IN_SIZE; i++) w_mem[i] = wv[p];
            for (int n = 0; n < OUT_SIZE; n++) b_mem[n] = 0;
            run_layer(1, -1, 2);
            tests_run++;
            if (wr_n !== 8 || wrr_n !== 8) begin
                tests_failed++; $display("FAIL sat_we_count[%0d]: got %0d/%0d expected 8/8", p, wr_n, wrr_n);
            end
            for (int n = 0; n < 8 && n < wr_n && n < wrr_n; n++) begin
                tests_run++;
                if (wr_data[n] !== exp_v[p] || wrr_data[n] !== exp_r[p]) begin
                    tests_failed++;
                    $display("FAIL sat_data[%0d][%0d]: got %0d/%0d expected %0d/%0d",
                             p, n, wr_data[n], wrr_data[n], exp_v[p], exp_r[p]);
                end
            end
        end
    endtask

    task automatic test_addr_seq();
        load_nominal();
        run_layer(1, -1, 2);
        for (int n = 0; n < OUT_SIZE; n++) begin
            for (int k = 0; k < IN_SIZE; k++) begin
                int c;
                c = n*NCYC + k + 1;
                tests_run++;
                if (ia_log[c] !== k || wa_log[c] !== n*IN_SIZE + k || ba_log[c] !== n) begin
                    tests_failed++;
                    $display("FAIL addr_seq[n%0d k%0d]: got in %0d w %0d b %0d expected in %0d w %0d b %0d",
                             n, k, ia_log[c], wa_log[c], ba_log[c], k, n*IN_SIZE + k, n);
                end
            end
        end
    endtask

    task automatic test_start_handling();
        load_random();
        // start held for three cycles
        run_layer(3, -1, 2);
        tests_run++;
        if (wr_n !== 8 || done_cnt !== 1 || done_rel !== 145) begin
            tests_failed++; $display("FAIL start_held: got we %0d done %0d at %0d expected 8 1 145", wr_n, done_cnt, done_rel);
        end
        tests_run++;
        if ({busy_log[146], busy_log[147]} !== 2'b00) begin
            tests_failed++; $display("FAIL start_held_idle: got busy %b expected 00", {busy_log[146], busy_log[147]});
        end
        // stray pulse mid-run, then a pulse during DONE
        run_layer(1, 40, 2);
        tests_run++;
        if (wr_n !== 8 || done_cnt !== 1 || done_rel !== 145) begin
            tests_failed++; $display("FAIL start_mid: got we %0d done %0d at %0d expected 8 1 145", wr_n, done_cnt, done_rel);
        end
        for (int n = 0; n < 8 && n < wr_n; n++) begin
            tests_run++;
            if (wr_data[n] !== ref_out(n, 0)) begin
                tests_failed++; $display("FAIL start_mid_data[%0d]: got %0d expected %0d", n, wr_data[n], ref_out(n, 0));
            end
        end
        run_layer(1, 145, 2);
        tests_run++;
        if ({busy_log[146], busy_log[147]} !== 2'b00 || done_cnt !== 1) begin
            tests_failed++; $display("FAIL start_in_done: got busy %b done %0d expected 00 1", {busy_log[146], busy_log[147]}, done_cnt);
        end
    endtask

    task automatic test_back_to_back();
        load_random();
        run_layer(1, -1, 1);
        tests_run++;
        if (done_rel !== 145 || wr_n !== 8) begin
            tests_failed++; $display("FAIL b2b_first: got done %0d we %0d expected 145 8", done_rel, wr_n);
        end
        run_layer(1, -1, 2);
        tests_run++;
        if (done_rel !== 145 || wr_n !== 8 || done_cnt !== 1) begin
            tests_failed++; $display("FAIL b2b_second: got done %0d we %0d cnt %0d expected 145 8 1", done_rel, wr_n, done_cnt);
        end
        for (int n = 0; n < 8 && n < wr_n; n++) begin
            tests_run++;
            if (wr_addr[n] !== n || wr_data[n] !== ref_out(n, 0)) begin
                tests_failed++;
                $display("FAIL b2b_data[%0d]: got addr %0d data %0d expected addr %0d data %0d",
                         n, wr_addr[n], wr_data[n], n, ref_out(n, 0));
            end
        end
    endtask

    task automatic test_reset_mid();
        int stray_we, stray_done, stray_busy;
        load_nominal();
        start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        // cycle 3*NCYC+5 is a RUN cycle of neuron 3
        repeat (3*NCYC + 4) begin @(posedge clk); @(negedge clk); end
        tests_run++;
        if (busy !== 1'b1 || b_addr !== 3'd3) begin
            tests_failed++; $display("FAIL abort_pre: got busy %b b_addr %0d expected 1 3", busy, b_addr);
        end
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        tests_run++;
        if ({busy, out_we, done} !== 3'b000) begin
            tests_failed++; $display("FAIL abort_ctrl: got %b expected 000", {busy, out_we, done});
        end
        tests_run++;
        if (out_data !== 8'sd0 || out_addr !== 3'd0 || w_addr !== 7'd0 || in_addr !== 4'd0) begin
            tests_failed++; $display("FAIL abort_outs: got data %0d oaddr %0d waddr %0d iaddr %0d expected 0",
                                     out_data, out_addr, w_addr, in_addr);
        end
        stray_we = 0; stray_done = 0; stray_busy = 0;
        repeat (160) begin
            @(posedge clk); @(negedge clk);
            stray_we += int'(out_we); stray_done += int'(done); stray_busy += int'(busy);
        end
        tests_run++;
        if (stray_we !== 0 || stray_done !== 0 || stray_busy !== 0) begin
            tests_failed++; $display("FAIL abort_quiet: got we %0d done %0d busy %0d expected 0 0 0",
                                     stray_we, stray_done, stray_busy);
        end
        run_layer(1, -1, 2);
        tests_run++;
        if (wr_n !== 8 || done_rel !== 145) begin
            tests_failed++; $display("FAIL abort_rerun: got we %0d done %0d expected 8 145", wr_n, done_rel);
        end
        for (int n = 0; n < 8 && n < wr_n; n++) begin
            tests_run++;
            if (wr_addr[n] !== n || wr_data[n] !== -12 + 4*n) begin
                tests_failed++; $display("FAIL abort_rerun_data[%0d]: got %0d expected %0d", n, wr_data[n], -12 + 4*n);
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            load_random();
            run_layer(1, -1, 2);
            tests_run++;
            if (wr_n !== 8 || wrr_n !== 8 || done_rel !== 145) begin
                tests_failed++; $display("FAIL rand_counts[%0d]: got we %0d/%0d done %0d expected 8/8 145",
                                         it, wr_n, wrr_n, done_rel);
            end
            for (int n = 0; n < 8 && n < wr_n && n < wrr_n; n++) begin
                tests_run++;
                if (wr_data[n] !== ref_out(n, 0) || wrr_data[n] !== ref_out(n, 1)) begin
                    tests_failed++;
                    $display("FAIL rand_data[%0d][%0d]: got %0d/%0d expected %0d/%0d",
                             it, n, wr_data[n], wrr_data[n], ref_out(n, 0), ref_out(n, 1));
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        for (int k = 0; k < IN_SIZE; k++) x_mem[k] = 0;
        for (int i = 0; i < OUT_SIZE*IN_SIZE; i++) w_mem[i] = 0;
        for (int n = 0; n < OUT_SIZE; n++) b_mem[n] = 0;
        test_reset();
        test_nominal();
        test_relu();
        test_saturation();
        test_addr_seq();
        test_start_handling();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
